// File: rtl/dds_burst_ctrl.sv
// Phase-accumulator sequencer for the DDS path: continuous output or phase-coherent
// bursts of whole waveform periods, with idle gaps, a repeat count and graceful stop.
module dds_burst_ctrl #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ACC_W-1:0]  freq_word,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic [CNT_W-1:0]  gap_len,
    input  logic [7:0]        repeat_cnt,
    output logic [ADDR_W-1:0] addr_out,
    output logic              dds_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_FINISH} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] fw_q, fw_d;
    logic [CNT_W-1:0] blen_q, blen_d;
    logic [CNT_W-1:0] glen_q, glen_d;
    logic [7:0]       rep_q, rep_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic [7:0]       bcnt_q, bcnt_d;
    logic             stopf_q, stopf_d;
    logic             en_q;

    logic [ACC_W:0]   sum;
    logic             wrap;
    logic [CNT_W-1:0] per_inc;
    logic [7:0]       bcnt_inc;
    logic             burst_end;

    // A wrap is the carry out of the phase add; stop only ends a burst on a later wrap.
    always_comb begin
        sum       = {1'b0, acc_q} + {1'b0, fw_q};
        wrap      = sum[ACC_W];
        per_inc   = per_q + CNT_W'(1);
        bcnt_inc  = bcnt_q + 8'd1;
        burst_end = wrap && (((blen_q != '0) && (per_inc == blen_q)) || stopf_q);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fw_d    = fw_q;
        blen_d  = blen_q;
        glen_d  = glen_q;
        rep_d   = rep_q;
        per_d   = per_q;
        gcnt_d  = gcnt_q;
        bcnt_d  = bcnt_q;
        stopf_d = stopf_q;
        case (state_q)
            S_IDLE: begin
                acc_d = '0;
                if (start && (freq_word != '0)) state_d = S_LOAD;
            end
            S_LOAD: begin
                fw_d    = freq_word;
                blen_d  = burst_len;
                glen_d  = gap_len;
                rep_d   = repeat_cnt;
                acc_d   = '0;
                per_d   = '0;
                bcnt_d  = '0;
                stopf_d = stop;
                state_d = S_RUN;
            end
            S_RUN: begin
                stopf_d = stopf_q | stop;
                acc_d   = sum[ACC_W-1:0];
                if (wrap) per_d = per_inc;
                if (burst_end) begin
                    // Restart at phase 0 rather than the wrap residue so every burst is coherent.
                    acc_d  = '0;
                    per_d  = '0;
                    bcnt_d = bcnt_inc;
                    if (stopf_q) begin
                        state_d = S_IDLE;
                    end else if ((rep_q != 8'd0) && (bcnt_inc == rep_q)) begin
                        state_d = S_FINISH;
                    end else if (glen_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_GAP;
                        gcnt_d  = glen_q;
                    end
                end
            end
            S_GAP: begin
                acc_d  = '0;
                gcnt_d = gcnt_q - CNT_W'(1);
                if (stop || stopf_q) begin
                    state_d = S_IDLE;
                end else if (gcnt_q == CNT_W'(1)) begin
                    state_d = S_RUN;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            fw_q    <= '0;
            blen_q  <= '0;
            glen_q  <= '0;
            rep_q   <= '0;
            per_q   <= '0;
            gcnt_q  <= '0;
            bcnt_q  <= '0;
            stopf_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fw_q    <= fw_d;
            blen_q  <= blen_d;
            glen_q  <= glen_d;
            rep_q   <= rep_d;
            per_q   <= per_d;
            gcnt_q  <= gcnt_d;
            bcnt_q  <= bcnt_d;
            stopf_q <= stopf_d;
            // Matches the one-clock ROM read latency.
            en_q    <= (state_q == S_RUN);
        end
    end

    assign addr_out = acc_q[ACC_W-1 -: ADDR_W];
    assign dds_en   = en_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FINISH);

endmodule

// File: tb/tb_dds_burst_ctrl.sv
// Bench for dds_burst_ctrl: a burst-level phase model predicts addr/en/busy/done per cycle.
module tb_dds_burst_ctrl;
    localparam int ACC_W  = 32;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;
    localparam int CAP    = 60000;

    typedef enum int {K_IDLE, K_LOAD, K_RUN, K_GAP, K_FIN} kind_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [ACC_W-1:0]  freq_word = '0;
    logic [CNT_W-1:0]  burst_len = '0;
    logic [CNT_W-1:0]  gap_len = '0;
    logic [7:0]        repeat_cnt = '0;
    logic [ADDR_W-1:0] addr_out;
    logic              dds_en, busy, done;

    int checks = 0;
    int errors = 0;

    kind_t       mk[$];
    int          ma[$];
    logic [10:0] obs[$];

    dds_burst_ctrl #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .freq_word(freq_word), .burst_len(burst_len), .gap_len(gap_len),
        .repeat_cnt(repeat_cnt), .addr_out(addr_out), .dds_en(dds_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int addr_at(longint unsigned i, longint unsigned fw);
        return int'(((i * fw) % 64'h1_0000_0000) >> (ACC_W - ADDR_W));
    endfunction

    // Expected per-cycle trace, entry 0 being the LOAD cycle. stop_idx is the entry
    // during which stop is held high (-1 for none).
    function automatic void build(longint unsigned fw, int blen, int glen, int rep, int stop_idx);
        int b;
        bit flag, fb, ended;
        longint unsigned i, pn, pc;
        mk.delete();
        ma.delete();
        mk.push_back(K_LOAD); ma.push_back(0);
        flag = (stop_idx == 0);
        b = 0;
        while (mk.size() < CAP) begin
            i = 0;
            do begin
                fb = flag;
                mk.push_back(K_RUN); ma.push_back(addr_at(i, fw));
                pc = (i * fw) >> 32;
                pn = ((i + 1) * fw) >> 32;
                ended = (pn != pc) && (((blen != 0) && (pn == longint'(blen))) || fb);
                if (mk.size() - 1 == stop_idx) flag = 1'b1;
                i++;
            end while (!ended && mk.size() < CAP);
            b++;
            if (fb) begin
                mk.push_back(K_IDLE); ma.push_back(0);
                mk.push_back(K_IDLE); ma.push_back(0);
                return;
            end
            if (rep != 0 && b == rep) begin
                mk.push_back(K_FIN);  ma.push_back(0);
                mk.push_back(K_IDLE); ma.push_back(0);
                mk.push_back(K_IDLE); ma.push_back(0);
                return;
            end
            for (int g = 0; g < glen; g++) begin
                mk.push_back(K_GAP); ma.push_back(0);
                if (flag || (mk.size() - 1 == stop_idx)) begin
                    mk.push_back(K_IDLE); ma.push_back(0);
                    mk.push_back(K_IDLE); ma.push_back(0);
                    return;
                end
            end
        end
    endfunction

    function automatic logic [10:0] exp_vec(int i);
        logic en;
        en = (i > 0) ? (mk[i-1] == K_RUN) : 1'b0;
        return {8'(ma[i]), en, mk[i] != K_IDLE, mk[i] == K_FIN};
    endfunction

    // Pulses start, then records {addr,en,busy,done} once per cycle for the model's length.
    task automatic play(int stop_idx, int poke_idx, bit scramble, bit stop_with_start);
        int n;
        n = mk.size();
        obs.delete();
        @(negedge clk); start = 1'b1; stop = stop_with_start;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            obs.push_back({addr_out, dds_en, busy, done});
            start = 1'b0;
            stop  = (i == stop_idx);
            if (i >= 1 && i < n - 2) begin
                if (i == poke_idx) begin
                    start = 1'b1;
                    freq_word = $urandom;
                end
                if (scramble) begin
                    start      = ($urandom_range(0, 7) == 0);
                    freq_word  = $urandom;
                    burst_len  = 16'($urandom);
                    gap_len    = 16'($urandom);
                    repeat_cnt = 8'($urandom);
                end
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({addr_out, dds_en, busy, done} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state got addr/en/busy/done=%h want 000", {addr_out, dds_en, busy, done});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({addr_out, dds_en, busy, done} !== 11'd0) begin
            errors++;
            $display("FAIL reset_release got %h want 000", {addr_out, dds_en, busy, done});
        end
    endtask

    task automatic test_single_burst;
        int en_cnt, done_at;
        freq_word = 32'h0100_0000; burst_len = 16'd2; gap_len = 16'd10; repeat_cnt = 8'd1;
        build(64'h0100_0000, 2, 10, 1, -1);
        play(-1, -1, 1'b0, 1'b0);
        for (int i = 0; i < mk.size(); i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
                errors++;
                if (errors < 30) $display("FAIL single_burst cyc %0d got addr,en,busy,done=%h want %h", i, obs[i], exp_vec(i));
            end
        end
        en_cnt = 0; done_at = -1;
        foreach (obs[i]) begin
            en_cnt += int'(obs[i][2]);
            if (obs[i][0] && done_at < 0) done_at = i;
        end
        checks++;
        if (en_cnt !== 512) begin errors++; $display("FAIL single_en_count got %0d want 512", en_cnt); end
        checks++;
        if (done_at !== 513) begin errors++; $display("FAIL single_done_time got %0d want 513", done_at); end
    endtask

    task automatic test_repeat_gap;
        int en_cnt, done_cnt;
        freq_word = 32'h0100_0000; burst_len = 16'd2; gap_len = 16'd10; repeat_cnt = 8'd3;
        build(64'h0100_0000, 2, 10, 3, -1);
        play(-1, -1, 1'b0, 1'b0);
        for (int i = 0; i < mk.size(); i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
                errors++;
                if (errors < 30) $display("FAIL repeat_gap cyc %0d got addr,en,busy,done=%h want %h", i, obs[i], exp_vec(i));
            end
        end
        en_cnt = 0; done_cnt = 0;
        foreach (obs[i]) begin
            en_cnt += int'(obs[i][2]);
            done_cnt += int'(obs[i][0]);
        end
        checks++;
        if (en_cnt !== 1536) begin errors++; $display("FAIL repeat_en_count got %0d want 1536", en_cnt); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL repeat_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_graceful_stop;
        int max_addr, done_cnt;
        freq_word = 32'h0200_0000; burst_len = 16'd0; gap_len = 16'd0; repeat_cnt = 8'd0;
        build(64'h0200_0000, 0, 0, 0, 33);
        play(33, -1, 1'b0, 1'b0);
        for (int i = 0; i < mk.size(); i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
                errors++;
                if (errors < 30) $display("FAIL graceful_stop cyc %0d got addr,en,busy,done=%h want %h", i, obs[i], exp_vec(i));
            end
        end
        max_addr = 0; done_cnt = 0;
        foreach (obs[i]) begin
            if (int'(obs[i][10:3]) > max_addr) max_addr = int'(obs[i][10:3]);
            done_cnt += int'(obs[i][0]);
        end
        checks++;
        if (max_addr !== 8'hFE) begin errors++; $display("FAIL stop_last_addr got %h want fe", max_addr); end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL stop_no_done got %0d want 0", done_cnt); end
    endtask

    task automatic test_ignored;
        freq_word = '0; burst_len = 16'd1; gap_len = 16'd0; repeat_cnt = 8'd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL zero_fw_start got busy=%b want 0", busy); end
            @(negedge clk);
        end
        // start+stop together in IDLE, then start and new freq_word while running.
        freq_word = 32'h0200_0000;
        build(64'h0200_0000, 1, 0, 1, -1);
        play(-1, 60, 1'b0, 1'b1);
        for (int i = 0; i < mk.size(); i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
                errors++;
                if (errors < 30) $display("FAIL ignored_req cyc %0d got addr,en,busy,done=%h want %h", i, obs[i], exp_vec(i));
            end
        end
    endtask

    task automatic test_stop_in_gap;
        int en_cnt, done_cnt;
        freq_word = 32'h0100_0000; burst_len = 16'd1; gap_len = 16'd10; repeat_cnt = 8'd3;
        build(64'h0100_0000, 1, 10, 3, 259);
        play(259, -1, 1'b0, 1'b0);
        for (int i = 0; i < mk.size(); i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
                errors++;
                if (errors < 30) $display("FAIL stop_in_gap cyc %0d got addr,en,busy,done=%h want %h", i, obs[i], exp_vec(i));
            end
        end
        en_cnt = 0; done_cnt = 0;
        foreach (obs[i]) begin
            en_cnt += int'(obs[i][2]);
            done_cnt += int'(obs[i][0]);
        end
        checks++;
        if (en_cnt !== 256) begin errors++; $display("FAIL gap_stop_en_count got %0d want 256", en_cnt); end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL gap_stop_no_done got %0d want 0", done_cnt); end
    endtask

    task automatic test_unlimited_stop;
        freq_word = 32'h0400_0000; burst_len = 16'd1; gap_len = 16'd3; repeat_cnt = 8'd0;
        build(64'h0400_0000, 1, 3, 0, 150);
        play(150, -1, 1'b0, 1'b0);
        for (int i = 0; i < mk.size(); i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
                errors++;
                if (errors < 30) $display("FAIL unlimited_stop cyc %0d got addr,en,busy,done=%h want %h", i, obs[i], exp_vec(i));
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] fw;
        int bl, gl, rp, si;
        for (int it = 0; it < 6; it++) begin
            fw = $urandom_range(32'h0100_0000, 32'h0400_0000);
            bl = $urandom_range(1, 3);
            gl = $urandom_range(0, 4);
            rp = $urandom_range(1, 3);
            si = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 500)) : -1;
            freq_word = fw; burst_len = 16'(bl); gap_len = 16'(gl); repeat_cnt = 8'(rp);
            build(64'(fw), bl, gl, rp, si);
            play(si, -1, 1'b1, 1'b0);
            for (int i = 0; i < mk.size(); i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    errors++;
                    if (errors < 30) $display("FAIL random it %0d fw %h cyc %0d got addr,en,busy,done=%h want %h", it, fw, i, obs[i], exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_async_reset;
        freq_word = 32'h0400_0000; burst_len = 16'd4; gap_len = 16'd0; repeat_cnt = 8'd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat ($urandom_range(5, 200)) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({addr_out, dds_en, busy, done} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset got addr,en,busy,done=%h want 000", {addr_out, dds_en, busy, done});
        end
        @(negedge clk); rst_n = 1'b1;
        build(64'h0400_0000, 4, 0, 1, -1);
        play(-1, -1, 1'b0, 1'b0);
        for (int i = 0; i < mk.size(); i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
                errors++;
                if (errors < 30) $display("FAIL after_reset cyc %0d got addr,en,busy,done=%h want %h", i, obs[i], exp_vec(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_repeat_gap();
        test_graceful_stop();
        test_ignored();
        test_stop_in_gap();
        test_unlimited_stop();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_burst_ctrl.md
# dds_burst_ctrl

Programmable sequencer for the DDS waveform path. It owns the phase accumulator and drives the waveform ROM address and the output gate (`dds_en`). It generates continuous output or phase-coherent bursts of N whole waveform periods, with programmable idle gaps and repeat count. It replaces the fixed-step address generator: `addr_out` feeds the ROM address input, and `dds_en` feeds the output AND gate.

## Interface
- `ACC_W`, 32: phase accumulator width.
- `ADDR_W`, 8: ROM address width; `ADDR_W <= ACC_W`.
- `CNT_W`, 16: width of the period and gap counters.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sequence.
- `stop`  in  1  one-cycle request to end a sequence gracefully.
- `freq_word`  in  ACC_W  phase increment per clock.
- `burst_len`  in  CNT_W  waveform periods per burst; 0 = continuous.
- `gap_len`  in  CNT_W  idle clocks between bursts.
- `repeat_cnt`  in  8  number of bursts; 0 = unlimited.
- `addr_out`  out  ADDR_W  ROM address, `acc[ACC_W-1 -: ADDR_W]`.
- `dds_en`  out  1  output gate, aligned to ROM data.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at normal sequence completion.

## Operation
- States: IDLE, LOAD, RUN, GAP, FINISH.
- **IDLE**
  - `acc` = 0.
  - `start` with `freq_word != 0` → LOAD.
  - `start` with `freq_word == 0` is ignored and stays IDLE.
- **LOAD**
  - Latch `freq_word`, `burst_len`, `gap_len`, `repeat_cnt` into shadow registers.
  - Clear `acc`, the period counter, the burst counter and the stop flag.
  - → RUN.
  - Inputs are not sampled again until the next LOAD.
- **RUN**
  - Each clock: `acc <= acc + fw_shadow`, modulo 2^ACC_W.
  - A wrap is the carry out of that add. Each wrap increments the period counter.
  - Burst end is the wrap cycle where the period count reaches `burst_len` (nonzero), or any wrap while the stop flag is set.
  - At burst end, `acc <= 0` (not the wrap residue), the period counter clears, and the burst counter increments. Then:
    - stop flag set → IDLE, no `done`;
    - `repeat_cnt != 0` and burst counter equals `repeat_cnt` → FINISH;
    - `gap_len == 0` → stay in RUN, next burst starts at phase 0;
    - otherwise → GAP, gap counter loaded with `gap_len`.
  - With `burst_len == 0`, only stop ends RUN.
- **GAP**
  - `acc` held at 0; counter decrements each clock.
  - When the counter reads 1 → RUN.
  - `stop`, or a stop flag already set → IDLE immediately.
- **FINISH**
  - `done` = 1 for exactly one cycle → IDLE.
- **Stop**
  - `stop` sampled in LOAD or RUN sets the stop flag.
  - The current period always completes; output is never truncated mid-period.
  - `stop` in IDLE or FINISH is ignored.
- **Start while busy** is ignored.
- **Simultaneous `start` and `stop` in IDLE:** `start` wins, and `stop` is discarded.

## Timing
- Reset values:
  - state IDLE; `acc`, all counters and shadow registers 0;
  - `addr_out` 0, `dds_en` 0, `busy` 0, `done` 0.
- Reset mid-sequence: all outputs return to reset values asynchronously.
- `start` high in cycle t:
  - LOAD in t+1;
  - first RUN cycle t+2, with `addr_out` = 0.
- The ROM has one clock of read latency. `dds_en` is the state==RUN flag delayed one register, so it is high exactly while ROM data for RUN addresses is presented.
- When `freq_word` divides 2^ACC_W, a burst lasts exactly `burst_len × 2^ACC_W / freq_word` RUN cycles.
- `busy` is high from LOAD through FINISH inclusive.
- `done` is high during the FINISH cycle.

## Test plan
- **Single burst:** ACC_W=32, ADDR_W=8, `freq_word`=0x0100_0000, `burst_len`=2, `gap_len`=10, `repeat_cnt`=1.
  - `addr_out` ramps 0..255 twice over 512 RUN cycles.
  - `dds_en` is high for 512 cycles, starting one cycle after the first RUN cycle.
  - `done` pulses once, 513 cycles after LOAD; `busy` then falls.
- **Repeat with gap:** same settings, `repeat_cnt`=3.
  - Three 512-cycle bursts, each starting at `addr_out`=0.
  - Two 10-cycle gaps with `dds_en`=0.
  - One `done` pulse.
- **Graceful stop:** continuous mode (`burst_len`=0), `freq_word`=0x0200_0000; pulse `stop` when `addr_out`=0x40.
  - RUN continues to the next wrap, with `addr_out` reaching 0xFE.
  - Then IDLE, `dds_en` falls one cycle later, and no `done`.
- **Ignored requests:**
  - `start` with `freq_word`=0 leaves `busy`=0.
  - `start` during RUN does not restart phase.
  - Changing `freq_word` mid-burst does not change the slope.
- **Stop in GAP:** `stop` in the 3rd gap cycle → IDLE next cycle; no further RUN and no `done`.
- **Async reset mid-RUN:** `rst_n` low at an arbitrary point → `addr_out`, `dds_en`, `busy` and `done` read 0 before the next clock edge; after release, a new `start` behaves normally.
